mem_port_scheduler: RTL
=======================

# mem_port_scheduler

Schedules a single memory target port among `NUM_REQ` requesters. Requester 0 is the latency-critical N64 PI path; the others are cfg and DMA engines.
- Fairness is round-robin with a bounded burst-hold per owner.
- Requester 0 has priority at every arbitration point, with a starvation guard so DMA traffic is never locked out.
- It sits between the request sources and one memory controller (SDRAM, flash or BRAM) and forwards exactly one transaction at a time.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `BURST_MAX`, default 8: consecutive transactions an owner may keep without re-arbitration, 1..255.
- `STARVE_LIMIT`, default 64: wait cycles after which requester-0 priority is suspended, 1..1023.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `req_request` in NUM_REQ: per-requester transaction request, held until acked.
- `req_write` in NUM_REQ: 1 = write.
- `req_address` in NUM_REQ×27: byte address, bit 0 ignored.
- `req_wdata` in NUM_REQ×16: write data.
- `req_wmask` in NUM_REQ×2: byte enables.
- `req_ack` out NUM_REQ: one-cycle completion pulse to the owner.
- `req_rdata` out 16: read data, valid with `req_ack`.
- `mem_request` out 1: request to the target.
- `mem_write` out 1: write strobe to the target.
- `mem_address` out 27: address to the target.
- `mem_wdata` out 16: write data to the target.
- `mem_wmask` out 2: byte enables to the target.
- `mem_ack` in 1: target completion pulse.
- `mem_rdata` in 16: target read data.
- `owner` out 3: index of the current/last granted requester, for debug/status.

## Operation
- States: IDLE, ISSUE.
- IDLE, choosing the next owner in priority order:
  - if the previous owner still requests and `burst_cnt < BURST_MAX`, it is re-granted with no arbitration;
  - else if `req_request[0]` is set and `starve` is clear, requester 0 is granted;
  - else round-robin search starts at `last+1`, wrapping modulo NUM_REQ; requester 0 is included in this search.
- On a grant:
  - owner index, write, address, wdata and wmask are latched into registers; state moves to ISSUE.
  - `burst_cnt` is set to 1 on an owner change, otherwise incremented, saturating at BURST_MAX.
- ISSUE: `mem_request` is 1 and the `mem_*` outputs come from the latched registers.
  - On `mem_ack`: `req_ack[owner]` pulses in the same cycle, `req_rdata = mem_rdata` (combinational), and state returns to IDLE.
- The owner is never preempted mid-transaction, including by requester 0.
- Starvation counter `wait_cnt` (10 bits): increments each cycle any requester other than the owner has `req_request` high and is not granted; clears on any grant to a non-zero requester.
  - When `wait_cnt ≥ STARVE_LIMIT`, `starve` is set.
  - `starve` clears on the next grant of a non-zero requester.
- A requester that drops `req_request` before being granted is simply skipped. No transaction is issued for it.
- `mem_ack` is ignored while in IDLE. `req_ack` stays 0.

## Timing
- Reset values: state IDLE; `mem_request` 0; `mem_write` 0; `mem_address` 0; `mem_wdata` 0; `mem_wmask` 0; `req_ack` 0; `owner` 0; `last` = NUM_REQ-1 (so the first round-robin search starts at 0); `burst_cnt` 0; `wait_cnt` 0; `starve` 0.
- Grant latency: a request seen in IDLE at edge n gives `mem_request` high from cycle n+1.
- Ack latency: `req_ack` is in the same cycle as `mem_ack`.
- Turnaround: one IDLE cycle between consecutive transactions. Peak rate is one transaction per (target latency + 1) cycles.
- A requester must not change its `req_*` fields while its request is high. The arbiter samples them only at grant.
- Reset asserted during ISSUE: `mem_request` drops immediately (asynchronous), the in-flight ack is lost, and requesters must re-request.
- Simultaneous requests by all requesters with starve clear: requester 0 wins.

## Structure
- A shared package (`mem_sched_pkg`) holds the `e_state` enum (IDLE, ISSUE) and the width constants `ADDR_W=27`, `DATA_W=16`.
- One sub-module, `rr_pick`: purely combinational round-robin selector. Inputs are the request vector and the start index; outputs are the valid flag and the chosen index.

## Test plan
- Single requester 2 writes 0xBEEF to 0x100, target acks after 3 cycles → `mem_request` from cycle 1, `req_ack[2]` pulses cycle 4, data/address match.
- Requesters 1, 2, 3 continuously request, BURST_MAX=2 → grant order 1,1,2,2,3,3,1…
- Requester 0 asserts while requester 2 is in ISSUE → requester 2 completes, requester 0 is granted in the next IDLE cycle.
- Requester 0 requests continuously with requester 1 waiting, STARVE_LIMIT=16 → requester 1 is granted within 16 + BURST_MAX×(target latency+1) cycles, and `starve` clears afterwards.
- Reset asserted mid-ISSUE → `mem_request` is 0 in the same cycle. After release, first grant goes to requester 0 if requesting, otherwise requester 1.
- Read from 0x2000 with `mem_rdata` 0x1234 → `req_rdata` 0x1234 coincident with `req_ack[owner]`. No spurious acks to other requesters.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// Shared types and widths for the memory port scheduler.
// Index width is fixed at 3 bits so up to 8 requesters fit the owner port.
package mem_sched_pkg;

  localparam int ADDR_W  = 27;
  localparam int DATA_W  = 16;
  localparam int IDX_W   = 3;
  localparam int BURST_W = 8;
  localparam int WAIT_W  = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } e_state;

  // Next index after idx, wrapping modulo n.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    return (idx == IDX_W'(n - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after start,
// wrapping modulo N.
module rr_pick
  import mem_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             vld,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  // Rotate so that bit 0 of rot is the requester at start.
  assign rot = N'({req, req} >> start);

  always_comb begin
    vld = 1'b0;
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        vld = 1'b1;
        off = IDX_W'(i);
      end
    end
  end

  assign sum = {1'b0, start} + {1'b0, off};
  assign idx = (sum >= (IDX_W + 1)'(N)) ? IDX_W'(sum - (IDX_W + 1)'(N)) : sum[IDX_W-1:0];

endmodule

// File: rtl/mem_port_scheduler.sv
// Arbitrates NUM_REQ requesters onto one memory target port, one transaction at a time.
// Requester 0 has priority, owners may hold for BURST_MAX grants, a starvation guard lifts requester-0 priority.
module mem_port_scheduler
  import mem_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BURST_MAX    = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_request,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*2-1:0]      req_wmask,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      mem_request,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [1:0]                mem_wmask,
  input  logic                      mem_ack,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [IDX_W-1:0]          owner
);

  e_state state_q, state_d;

  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   last_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [1:0]         wmask_q;
  logic [BURST_W-1:0] burst_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               starve;

  logic               grant_vld;
  logic [IDX_W-1:0]   grant_idx;
  logic               owner_req;
  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] grant_oh;
  logic               g_write;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_wdata;
  logic [1:0]         g_wmask;
  logic               rr_vld;
  logic [IDX_W-1:0]   rr_idx;
  logic               wait_inc;

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req   (req_request),
    .start (wrap_inc(last_q, NUM_REQ)),
    .vld   (rr_vld),
    .idx   (rr_idx)
  );

  always_comb begin
    owner_req = 1'b0;
    owner_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_req   = req_request[i];
        owner_oh[i] = 1'b1;
      end
    end
  end

  // Burst hold first, then requester-0 priority, then fair round-robin.
  always_comb begin
    state_d   = state_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    case (state_q)
      IDLE: begin
        if (burst_cnt != '0 && owner_req && burst_cnt < BURST_W'(BURST_MAX)) begin
          grant_vld = 1'b1;
          grant_idx = owner_q;
        end else if (req_request[0] && !starve) begin
          grant_vld = 1'b1;
          grant_idx = '0;
        end else if (rr_vld) begin
          grant_vld = 1'b1;
          grant_idx = rr_idx;
        end
        if (grant_vld) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    g_write  = 1'b0;
    g_addr   = '0;
    g_wdata  = '0;
    g_wmask  = '0;
    grant_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        g_write     = req_write[i];
        g_addr      = req_address[i*ADDR_W +: ADDR_W];
        g_wdata     = req_wdata[i*DATA_W +: DATA_W];
        g_wmask     = req_wmask[i*2 +: 2];
        grant_oh[i] = grant_vld;
      end
    end
  end

  // Anyone besides the owner left waiting this cycle feeds the starvation count.
  assign wait_inc = |(req_request & ~owner_oh & ~grant_oh);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q   <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      burst_cnt <= '0;
    end else if (grant_vld) begin
      owner_q <= grant_idx;
      last_q  <= grant_idx;
      wr_q    <= g_write;
      addr_q  <= g_addr;
      wdata_q <= g_wdata;
      wmask_q <= g_wmask;
      if (grant_idx != owner_q || burst_cnt == '0) begin
        burst_cnt <= BURST_W'(1);
      end else if (burst_cnt < BURST_W'(BURST_MAX)) begin
        burst_cnt <= burst_cnt + BURST_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else if (grant_vld && grant_idx != '0) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else begin
      if (wait_inc && wait_cnt != '1) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (wait_cnt >= WAIT_W'(STARVE_LIMIT)) begin
        starve <= 1'b1;
      end
    end
  end

  assign mem_request = (state_q == ISSUE);
  assign mem_write   = mem_request & wr_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wmask   = wmask_q;
  assign req_ack     = (mem_request && mem_ack) ? owner_oh : '0;
  assign req_rdata   = mem_rdata;
  assign owner       = owner_q;

endmodule
